// File: rtl/prog_down_count_bcd_pkg.sv
// Shared types and constants for the programmable two-digit BCD down-counter.
// Also holds the binary-to-BCD conversion that is used only when a preset is loaded.
package prog_down_count_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COUNTING,
        DONE
    } state_t;

    localparam int BCD_MAX_DIGIT   = 9;
    localparam int DEFAULT_MAX_VAL = 99;
    localparam int DEFAULT_W       = 7;

    // Double-dabble conversion. The preset is saturated to 99 first, so the tens digit is at most 9.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
        logic [14:0] sh;
        sh = {8'd0, bin};
        for (int i = 0; i < 7; i++) begin
            if (sh[10:7] >= 4'd5) sh[10:7] = sh[10:7] + 4'd3;
            if (sh[14:11] >= 4'd5) sh[14:11] = sh[14:11] + 4'd3;
            sh = {sh[13:0], 1'b0};
        end
        return sh[14:7];
    endfunction

endpackage

// File: rtl/prog_down_count_bcd_if.sv
// Control and status bundle of the BCD down-counter.
// The master side drives load, run and tick. The slave side is the counter.
interface prog_down_count_bcd_if
    import prog_down_count_bcd_pkg::*;
#(
    parameter int W = DEFAULT_W
);
    logic [W-1:0] preset;
    logic         load;
    logic         run;
    logic         tick;
    logic [W-1:0] count_out;
    logic [3:0]   bcd_tens;
    logic [3:0]   bcd_ones;
    logic         busy;
    logic         expired;
    logic         done;

    modport master (
        output preset, load, run, tick,
        input  count_out, bcd_tens, bcd_ones, busy, expired, done
    );

    modport slave (
        input  preset, load, run, tick,
        output count_out, bcd_tens, bcd_ones, busy, expired, done
    );
endinterface

// File: rtl/prog_down_count_bcd_bcd_digit_down.sv
// One registered BCD digit that supports load and decrement.
// When the digit decrements from 0 it wraps to 9 and raises a borrow.
module bcd_digit_down
    import prog_down_count_bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_en,
    output logic [3:0] digit,
    output logic       borrow_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= load_val;
        end else if (dec_en) begin
            digit <= (digit == 4'd0) ? 4'(BCD_MAX_DIGIT) : digit - 4'd1;
        end
    end

    assign borrow_out = dec_en && (digit == 4'd0);

endmodule

// File: rtl/prog_down_count_bcd.sv
// Programmable two-digit down-counter with both binary and BCD outputs.
// The BCD digits are kept in step with the binary count by decrementing them in BCD.
module prog_down_count_bcd
    import prog_down_count_bcd_pkg::*;
#(
    parameter int MAX_VAL = DEFAULT_MAX_VAL,
    parameter int W       = DEFAULT_W
)
(
    input  logic                  CLK,
    input  logic                  RST,
    prog_down_count_bcd_if.slave  bus
);

    state_t       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] sat_val;
    logic [7:0]   bcd_load;
    logic         busy_q, expired_q, done_q;
    logic         do_load, do_dec;
    logic         ones_borrow, tens_borrow_unused;
    logic [3:0]   tens_digit, ones_digit;

    assign sat_val  = (bus.preset > W'(MAX_VAL)) ? W'(MAX_VAL) : bus.preset;
    assign bcd_load = bin_to_bcd(7'(sat_val));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            count_q   <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            busy_q    <= (state_d == ARMED) || (state_d == COUNTING);
            expired_q <= (state_d == DONE);
            done_q    <= (state_d == DONE) && (state_q != DONE);
        end
    end

    // A tick is honoured in the same cycle that run rises from ARMED.
    // Reaching zero is the only way to enter DONE, so the count never underflows.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        do_load = 1'b0;
        do_dec  = 1'b0;
        if (bus.load) begin
            do_load = 1'b1;
            count_d = sat_val;
            if (sat_val == '0)  state_d = IDLE;
            else if (bus.run)   state_d = COUNTING;
            else                state_d = ARMED;
        end else begin
            case (state_q)
                ARMED, COUNTING: begin
                    if (!bus.run) begin
                        state_d = ARMED;
                    end else begin
                        state_d = COUNTING;
                        if (bus.tick) begin
                            do_dec  = 1'b1;
                            count_d = count_q - W'(1);
                            if (count_q == W'(1)) state_d = DONE;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    bcd_digit_down u_ones (
        .clk        (CLK),
        .rst        (RST),
        .load       (do_load),
        .load_val   (bcd_load[3:0]),
        .dec_en     (do_dec),
        .digit      (ones_digit),
        .borrow_out (ones_borrow)
    );

    bcd_digit_down u_tens (
        .clk        (CLK),
        .rst        (RST),
        .load       (do_load),
        .load_val   (bcd_load[7:4]),
        .dec_en     (ones_borrow),
        .digit      (tens_digit),
        .borrow_out (tens_borrow_unused)
    );

    assign bus.count_out = count_q;
    assign bus.bcd_tens  = tens_digit;
    assign bus.bcd_ones  = ones_digit;
    assign bus.busy      = busy_q;
    assign bus.expired   = expired_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_prog_down_count_bcd.sv
// Bench for prog_down_count_bcd. Each step pushes the expected outputs to a queue, and the scenario task
// pops that entry after the clock edge and compares it with the DUT outputs.
module tb_prog_down_count_bcd;
    import prog_down_count_bcd_pkg::*;

    localparam int W = 7;

    logic CLK = 1'b0;
    logic RST;

    prog_down_count_bcd_if #(.W(W)) bus ();

    prog_down_count_bcd #(.MAX_VAL(99), .W(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int          errors  = 0;
    int          checks  = 0;
    bit          started = 1'b0;
    logic [17:0] sb[$];
    int          m_val   = 0;
    state_t      m_state = IDLE;
    logic        m_done  = 1'b0;

    function automatic logic [17:0] pack(int val, state_t st, logic dn);
        logic [6:0] v7;
        v7 = 7'(val);
        return {v7, 4'(val / 10), 4'(val % 10), (st == ARMED) || (st == COUNTING), st == DONE, dn};
    endfunction

    function automatic logic [17:0] observed();
        return {bus.count_out, bus.bcd_tens, bus.bcd_ones, bus.busy, bus.expired, bus.done};
    endfunction

    function automatic string fmt(logic [17:0] v);
        return $sformatf("cnt=%0d bcd=%0d/%0d busy=%b expired=%b done=%b",
                         v[17:11], v[10:7], v[6:3], v[2], v[1], v[0]);
    endfunction

    // The next values follow the spec: reset wins, then load, then a tick gated by run.
    task automatic step(input int rst, input int ld, input int pre, input int rn, input int tk);
        RST        = (rst != 0);
        bus.load   = (ld != 0);
        bus.preset = 7'(pre);
        bus.run    = (rn != 0);
        bus.tick   = (tk != 0);
        m_done = 1'b0;
        if (rst != 0) begin
            m_val   = 0;
            m_state = IDLE;
        end else if (ld != 0) begin
            m_val   = (pre > 99) ? 99 : pre;
            m_state = (m_val == 0) ? IDLE : ((rn != 0) ? COUNTING : ARMED);
        end else if (m_state == ARMED || m_state == COUNTING) begin
            if (rn == 0) begin
                m_state = ARMED;
            end else if (tk != 0) begin
                m_val   = m_val - 1;
                m_state = (m_val == 0) ? DONE : COUNTING;
                m_done  = (m_val == 0);
            end else begin
                m_state = COUNTING;
            end
        end
        sb.push_back(pack(m_val, m_state, m_done));
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (started) begin
            checks++;
            if (int'(bus.count_out) !== 10 * int'(bus.bcd_tens) + int'(bus.bcd_ones)) begin
                errors++;
                $display("[TB] FAIL bcd_invariant: got cnt=%0d bcd=%0d/%0d, want cnt == 10*tens+ones",
                         bus.count_out, bus.bcd_tens, bus.bcd_ones);
            end
        end
    end

    task automatic test_reset();
        logic [17:0] e;
        for (int i = 0; i < 5; i++) begin
            if (i < 2) step(1, 0, 0, 0, 0);
            else       step(0, 0, 0, 1, 1);
            if (i == 1) started = 1'b1;
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("[TB] FAIL reset[%0d]: got %s, want %s", i, fmt(observed()), fmt(e));
            end
        end
    endtask

    task automatic test_countdown_12();
        logic [17:0] e;
        int pulses = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0)       step(0, 1, 12, 1, 0);
            else if (i < 15)  step(0, 0, 0, 1, 1);
            else              step(0, 1, 0, 1, 1);
            pulses += int'(bus.done);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("[TB] FAIL countdown12[%0d]: got %s, want %s", i, fmt(observed()), fmt(e));
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("[TB] FAIL countdown12_pulses: got %0d done pulses, want 1", pulses);
        end
    endtask

    task automatic test_saturation();
        logic [17:0] e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) step(0, 1, 120, 0, 0);
            else        step(0, 0, 0, 1, 1);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("[TB] FAIL saturation[%0d]: got %s, want %s", i, fmt(observed()), fmt(e));
            end
        end
    endtask

    task automatic test_run_pause();
        logic [17:0] e;
        int run_pat[8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        int done_at = -1;
        step(0, 1, 5, 1, 0);
        e = sb.pop_front();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("[TB] FAIL run_pause_load: got %s, want %s", fmt(observed()), fmt(e));
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, run_pat[i], 1);
            if (bus.done === 1'b1) done_at = i;
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("[TB] FAIL run_pause[%0d]: got %s, want %s", i, fmt(observed()), fmt(e));
            end
        end
        checks++;
        if (done_at !== 7) begin
            errors++;
            $display("[TB] FAIL run_pause_done_at: got tick index %0d, want 7", done_at);
        end
    endtask

    task automatic test_load_tick_collision();
        logic [17:0] e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) step(0, 1, 7, 1, 0);
            else        step(0, 1, 30, 1, 1);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("[TB] FAIL load_tick[%0d]: got %s, want %s", i, fmt(observed()), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] e;
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      step(0, 1, 3, 1, 0);
            else if (i < 3)  step(0, 0, 0, 1, 1);
            else if (i == 3) step(1, 0, 0, 1, 1);
            else             step(0, 0, 0, 1, 1);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("[TB] FAIL reset_mid[%0d]: got %s, want %s", i, fmt(observed()), fmt(e));
            end
        end
    endtask

    task automatic test_load_zero();
        logic [17:0] e;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       step(0, 1, 1, 1, 0);
                1:       step(0, 0, 0, 1, 1);
                2:       step(0, 1, 0, 1, 0);
                default: step(0, 0, 0, 1, 1);
            endcase
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("[TB] FAIL load_zero[%0d]: got %s, want %s", i, fmt(observed()), fmt(e));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        int pre;
        for (int i = 0; i < 120; i++) begin
            pre = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 12));
            step(($urandom_range(0, 39) == 0) ? 1 : 0,
                 ($urandom_range(0, 7) == 0) ? 1 : 0,
                 pre,
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, 1)));
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("[TB] FAIL random[%0d]: got %s, want %s", i, fmt(observed()), fmt(e));
            end
        end
    endtask

    initial begin
        RST        = 1'b1;
        bus.load   = 1'b0;
        bus.preset = '0;
        bus.run    = 1'b0;
        bus.tick   = 1'b0;
        $display("[TB] starting prog_down_count_bcd bench");
        test_reset();
        test_countdown_12();
        test_saturation();
        test_run_pause();
        test_load_tick_collision();
        test_reset_mid();
        test_load_zero();
        test_back_to_back();
        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
